// File: rtl/axi_default_param_pkg.sv
// Default AXI4-Lite widths and the request/response payload structs shared by managers and subordinates.
package axi_default_param_pkg;

  localparam int unsigned AXI4L_ADDR_WIDTH = 32;
  localparam int unsigned AXI4L_DATA_WIDTH = 64;
  localparam int unsigned AXI4L_STRB_WIDTH = AXI4L_DATA_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI4L_ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]                  aw_prot;
    logic                        aw_valid;
    logic [AXI4L_DATA_WIDTH-1:0] w_data;
    logic [AXI4L_STRB_WIDTH-1:0] w_strb;
    logic                        w_valid;
    logic                        b_ready;
    logic [AXI4L_ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]                  ar_prot;
    logic                        ar_valid;
    logic                        r_ready;
  } axi4l_req_t;

  typedef struct packed {
    logic                        aw_ready;
    logic                        w_ready;
    logic                        b_valid;
    logic [1:0]                  b_resp;
    logic                        ar_ready;
    logic                        r_valid;
    logic [AXI4L_DATA_WIDTH-1:0] r_data;
    logic [1:0]                  r_resp;
  } axi4l_resp_t;

endpackage

// File: rtl/axi4l_reg_sub.sv
// AXI4-Lite register subordinate with a flat register image output.
// Define AXI4L_REG_SUB_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4l_reg_sub #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter type axi4l_req_t  = axi_default_param_pkg::axi4l_req_t,
  parameter type axi4l_resp_t = axi_default_param_pkg::axi4l_resp_t
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  axi4l_req_t                     req_i,
  output axi4l_resp_t                    resp_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OB     = $clog2(STRB_W);
  localparam int unsigned IDXW   = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] REGION = ADDR_WIDTH'(NUM_REGS * STRB_W);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4L_REG_SUB_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic                    ready_en_q;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]       w_strb_q, w_strb_d;
  logic                    b_valid_q, b_valid_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic                    r_valid_q, r_valid_d;
  logic [1:0]              r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic                    aw_ready_c, w_ready_c, ar_ready_c;
  logic                    aw_hs_c, w_hs_c, ar_hs_c;
  logic [ADDR_WIDTH-1:0]   wr_addr_c, wr_off_c, rd_off_c;
  logic [DATA_WIDTH-1:0]   wr_data_c;
  logic [STRB_W-1:0]       wr_strb_c;
  logic                    wr_oor_c, rd_oor_c;
  logic [IDXW-1:0]         wr_idx_c, rd_idx_c;

  // Write channel: either of AW/W may arrive first; the commit uses whichever copy is live.
  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    regs_d     = regs_q;

    aw_ready_c = ready_en_q & ~aw_held_q & (w_state_q == W_IDLE);
    w_ready_c  = ready_en_q & ~w_held_q & (w_state_q == W_IDLE);
    aw_hs_c    = req_i.aw_valid & aw_ready_c;
    w_hs_c     = req_i.w_valid & w_ready_c;
    wr_addr_c  = aw_held_q ? aw_addr_q : req_i.aw_addr;
    wr_data_c  = w_held_q ? w_data_q : req_i.w_data;
    wr_strb_c  = w_held_q ? w_strb_q : req_i.w_strb;
    wr_off_c   = wr_addr_c - BASE_ADDR;
    wr_oor_c   = (wr_addr_c < BASE_ADDR) | (wr_off_c >= REGION);
    wr_idx_c   = wr_off_c[OB +: IDXW];

    if (aw_hs_c) begin
      aw_held_d = 1'b1;
      aw_addr_d = req_i.aw_addr;
    end
    if (w_hs_c) begin
      w_held_d = 1'b1;
      w_data_d = req_i.w_data;
      w_strb_d = req_i.w_strb;
    end

    unique case (w_state_q)
      W_IDLE: begin
        if ((aw_held_q | aw_hs_c) && (w_held_q | w_hs_c)) begin
          if (!wr_oor_c) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
              if (wr_strb_c[b]) regs_d[wr_idx_c][8*b +: 8] = wr_data_c[8*b +: 8];
            end
          end
          b_valid_d = 1'b1;
          b_resp_d  = wr_oor_c ? RESP_OOR : RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (req_i.b_ready) begin
          b_valid_d = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel samples the pre-commit register value, so a same-cycle write is not visible.
  always_comb begin
    r_state_d  = r_state_q;
    r_valid_d  = r_valid_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;

    ar_ready_c = ready_en_q & (r_state_q == R_IDLE);
    ar_hs_c    = req_i.ar_valid & ar_ready_c;
    rd_off_c   = req_i.ar_addr - BASE_ADDR;
    rd_oor_c   = (req_i.ar_addr < BASE_ADDR) | (rd_off_c >= REGION);
    rd_idx_c   = rd_off_c[OB +: IDXW];

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_data_d  = rd_oor_c ? '0 : regs_q[rd_idx_c];
          r_resp_d  = rd_oor_c ? RESP_OOR : RESP_OKAY;
          r_valid_d = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (req_i.r_ready) begin
          r_valid_d = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ready_en_q <= 1'b0;
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      for (int k = 0; k < int'(NUM_REGS); k++) regs_q[k] <= '0;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    resp_o          = '0;
    resp_o.aw_ready = aw_ready_c;
    resp_o.w_ready  = w_ready_c;
    resp_o.b_valid  = b_valid_q;
    resp_o.b_resp   = b_resp_q;
    resp_o.ar_ready = ar_ready_c;
    resp_o.r_valid  = r_valid_q;
    resp_o.r_data   = r_data_q;
    resp_o.r_resp   = r_resp_q;
  end

  for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_regs_o
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

  // Protection attributes carry no meaning for this register file.
  logic unused_prot;
  assign unused_prot = ^{req_i.aw_prot, req_i.ar_prot};

endmodule
